// File: rtl/bit_demux_deserializer.sv
// bit_demux_deserializer: demultiplexes accepted serial bits into word slots and
// hands complete words to a one-entry valid/ready output register.
module bit_demux_deserializer #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             frame_start,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CW-1:0]    slot,
  output logic             frame_err
);
  localparam logic [CW-1:0] MAX = CW'(WIDTH - 1);
  logic [CW-1:0] cnt, eff_cnt, tgt;
  logic [WIDTH-1:0] asm_q, merged;
  logic accept, last;
  assign slot = cnt;
  always_comb begin
    eff_cnt = frame_start ? '0 : cnt;
    tgt = MSB_FIRST ? MAX - eff_cnt : eff_cnt;
    bit_ready = !(cnt == MAX && word_valid && !word_ready);
    accept = bit_valid && bit_ready;
    last = eff_cnt == MAX;
    merged = asm_q;
    merged[tgt] = bit_in;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      asm_q <= '0;
      word_out <= '0;
      word_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_start && cnt != '0;
      if (accept) begin
        cnt <= last ? '0 : eff_cnt + 1'b1;
        asm_q <= last ? '0 : merged;
      end else if (frame_start) begin
        cnt <= '0;
        asm_q <= '0;
      end
      // a completing word may replace the one being consumed on the same edge
      if (accept && last) begin
        word_out <= merged;
        word_valid <= 1'b1;
      end else if (word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/bit_demux_deserializer.md
Name: bit_demux_deserializer

Overview:
- Receive end of the bit-serial datapath. Each accepted serial bit is demultiplexed into one slot of an assembly register, selected by a slot counter. Full words are handed to a one-entry output holding register.
- Serves as the counterpart to the mux-tree serializer: the mux picks one bit out of a word, and this block puts each bit back into its slot.
- Feeds the stack datapath with parallel words through a valid/ready handshake.

Parameters:
- WIDTH, 8, word width in bits; power of two, at least 2.
- MSB_FIRST, 1, 1 means the first bit of a frame lands in slot WIDTH-1; 0 means it lands in slot 0.
- CW, $clog2(WIDTH), slot counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  block can accept a bit this cycle.
- frame_start  in  1  resynchronise: the current bit, or the next accepted bit, is bit 0 of a new word.
- word_out  out  WIDTH  assembled word.
- word_valid  out  1  word_out holds a complete word.
- word_ready  in  1  downstream consumes word_out.
- slot  out  CW  current slot counter value, for debug.
- frame_err  out  1  one-cycle pulse: a resync discarded a partial word.

Behaviour:
- Reset (async, rst_n low): cnt=0, assembly register=0, word_out=0, word_valid=0, frame_err=0. All of these hold while rst_n is low. Reset mid-word discards the partial word and any held output word.
- Accept rule: a bit is accepted on a rising clk edge when bit_valid and bit_ready are both 1.
- Slot index:
  - Define eff_cnt = 0 if frame_start is high, else cnt.
  - Target slot = WIDTH-1-eff_cnt when MSB_FIRST=1, else eff_cnt.
  - Only the target slot of the assembly register loads; all other slots hold.
- Counter update:
  - On accept with eff_cnt < WIDTH-1: cnt <= eff_cnt+1.
  - On accept with eff_cnt == WIDTH-1: cnt <= 0 (wrap).
- Word completion, on the accept where eff_cnt == WIDTH-1:
  - word_out <= assembly register with the final bit merged in.
  - word_valid <= 1; visible the cycle after the last bit (latency 1).
  - Assembly register cleared to 0.
- bit_ready:
  - Combinational: 0 only when cnt == WIDTH-1 and word_valid=1 and word_ready=0; otherwise 1.
  - Non-final bits are always accepted while an output word is pending.
  - Combinational path word_ready -> bit_ready is allowed.
- Output handshake:
  - word_valid=1 and word_ready=1 -> word consumed; word_valid <= 0 unless a new word completes on the same edge.
  - Simultaneous consume and complete: word_out <= new word, word_valid stays 1. No bubble, no loss.
  - While word_valid=1 and word_ready=0, word_out is held stable.
- frame_start with no accepted bit:
  - cnt <= 0, assembly register cleared.
  - frame_err pulses 1 the next cycle if cnt != 0; otherwise no pulse.
- frame_start with an accepted bit:
  - Bit written to slot for eff_cnt=0; cnt <= 1.
  - frame_err pulses if the pre-edge cnt != 0.
- frame_start never affects word_out or word_valid.
- frame_err is a single-cycle pulse and is 0 otherwise.
- slot reflects the registered cnt.
- Throughput: with word_ready held 1, one word per WIDTH accepted bits, with no stall cycles.
- Structure: synchronous logic only beyond the async reset; no latches; single clock domain.

Test Plan:
- MSB_FIRST=1, WIDTH=8; bits 1,0,1,1,0,0,1,0 on consecutive cycles with word_ready=1 -> word_out=0xB2 and word_valid=1 for exactly one cycle, the cycle after the 8th bit; slot returns to 0.
- Same stream with MSB_FIRST=0 -> word_out=0x4D.
- Backpressure:
  - Send 0xB2 then 0x5A continuously with word_ready=0.
  - Required: bit_ready drops only when slot=7 with 0xB2 still pending; the 8th bit of 0x5A is stalled.
  - Raise word_ready: 0xB2 consumed, same edge loads 0x5A, word_valid stays 1, no bit lost.
- Resync:
  - After 3 bits, assert frame_start with bit_valid=1, then stream 0xA5.
  - Required: frame_err pulses 1 for one cycle; word_out=0xA5 after 8 bits counted from the frame_start bit.
  - frame_start at slot=0 gives no frame_err.
- Reset mid-word:
  - Drop rst_n asynchronously (no clock edge) after 5 bits with a word pending.
  - Required: word_valid=0, word_out=0, slot=0 immediately; the next 8 bits assemble a clean word.
- Back-to-back:
  - 4 consecutive words 0x01, 0x80, 0xFF, 0x00 with word_ready=1.
  - Required: bit_ready constantly 1; word_valid pulses every 8 cycles with correct values.
